// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch history table predictor:
// clear-FSM state encoding, counter arithmetic and the reset-value default.
package bp_pkg;

    // Widest counter supported; narrower counters are zero-extended into this.
    localparam int unsigned CTR_W_MAX = 4;

    typedef logic [CTR_W_MAX-1:0] ctr_t;

    typedef enum logic {
        ST_IDLE,
        ST_SWEEP
    } clr_state_e;

    // Weakly not-taken: the value just below the taken/not-taken midpoint.
    function automatic int unsigned ctr_init_default(input int unsigned width);
        return (32'd1 << (width - 32'd1)) - 32'd1;
    endfunction

    // Largest value representable in a counter of the given width.
    function automatic ctr_t ctr_max(input int unsigned width);
        return ctr_t'((32'd1 << width) - 32'd1);
    endfunction

    // Saturating step: limits are tested before the add so the result never wraps.
    function automatic ctr_t sat_next(input ctr_t ctr, input logic taken,
                                      input int unsigned width);
        ctr_t top;
        top = ctr_max(width);
        if (taken) begin
            return (ctr == top) ? ctr : ctr + ctr_t'(1);
        end
        return (ctr == '0) ? ctr : ctr - ctr_t'(1);
    endfunction

    // A counter is strong when pinned at either end of its range.
    function automatic logic ctr_is_strong(input ctr_t ctr, input int unsigned width);
        return (ctr == '0) || (ctr == ctr_max(width));
    endfunction

endpackage

// File: rtl/bht_sat_predictor_sat_ctr_next.sv
// Combinational saturating increment/decrement of one CTR_W-bit counter.
module sat_ctr_next
    import bp_pkg::*;
#(
    parameter int unsigned CTR_W = 2
) (
    input  logic [CTR_W-1:0] i_ctr,
    input  logic             i_taken,
    output logic [CTR_W-1:0] o_next
);

    // Widen into the package counter type, step, and narrow back.
    always_comb begin
        o_next = CTR_W'(sat_next(ctr_t'(i_ctr), i_taken, CTR_W));
    end

endmodule

// File: rtl/bht_sat_predictor.sv
// Branch history table of saturating counters: registered prediction for
// fetch, training from execute feedback, and a one-entry-per-cycle clear sweep.
module bht_sat_predictor
    import bp_pkg::*;
#(
    parameter int unsigned INDEX_W  = 8,
    parameter int unsigned CTR_W    = 2,
    parameter int unsigned CTR_INIT = ctr_init_default(CTR_W),
    parameter bit          BYPASS   = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               lu_valid,
    input  logic [INDEX_W-1:0] lu_index,
    output logic               pred_valid,
    output logic               pred_taken,
    output logic               pred_strong,
    input  logic               fb_valid,
    input  logic [INDEX_W-1:0] fb_index,
    input  logic               fb_taken,
    input  logic               clear,
    output logic               busy
);

    localparam int unsigned      ENTRIES = 2 ** INDEX_W;
    localparam logic [CTR_W-1:0] INIT_V  = CTR_W'(CTR_INIT);

    logic [CTR_W-1:0]   r_table [ENTRIES];
    clr_state_e         r_state;
    clr_state_e         w_state_nxt;
    logic [INDEX_W-1:0] r_ptr;
    logic [INDEX_W-1:0] w_ptr_nxt;

    logic               r_pred_valid;
    logic               r_pred_taken;
    logic               r_pred_strong;

    logic               w_sweep;
    logic               w_wr_en;
    logic [INDEX_W-1:0] w_wr_idx;
    logic [CTR_W-1:0]   w_wr_val;
    logic [CTR_W-1:0]   w_upd_next;
    logic [CTR_W-1:0]   w_byp_next;
    logic               w_hit;
    logic [CTR_W-1:0]   w_sel;
    logic               w_sel_strong;

    // Trained value for the feedback entry.
    sat_ctr_next #(.CTR_W(CTR_W)) u_upd (
        .i_ctr   (r_table[fb_index]),
        .i_taken (fb_taken),
        .o_next  (w_upd_next)
    );

    // Trained value for the lookup entry, used only on a same-index hit.
    sat_ctr_next #(.CTR_W(CTR_W)) u_byp (
        .i_ctr   (r_table[lu_index]),
        .i_taken (fb_taken),
        .o_next  (w_byp_next)
    );

    // Clear FSM next state: start on clear, walk the pointer, stop after the last entry.
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (clear) begin
                    w_state_nxt = ST_SWEEP;
                    w_ptr_nxt   = '0;
                end
            end
            ST_SWEEP: begin
                w_ptr_nxt = r_ptr + INDEX_W'(1);
                if (&r_ptr) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    // Clear FSM state and sweep pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Single write port: the sweep owns it while active, feedback otherwise.
    always_comb begin
        w_sweep  = (r_state == ST_SWEEP);
        w_wr_en  = w_sweep | fb_valid;
        w_wr_idx = w_sweep ? r_ptr : fb_index;
        w_wr_val = w_sweep ? INIT_V : w_upd_next;
    end

    // Counter table: fully initialised by reset, one entry written per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                r_table[i] <= INIT_V;
            end
        end else if (w_wr_en) begin
            r_table[w_wr_idx] <= w_wr_val;
        end
    end

    // Prediction source: forced during a sweep, bypassed on a same-index update.
    always_comb begin
        w_hit = BYPASS && fb_valid && !w_sweep && (fb_index == lu_index);
        if (w_sweep) begin
            w_sel = INIT_V;
        end else if (w_hit) begin
            w_sel = w_byp_next;
        end else begin
            w_sel = r_table[lu_index];
        end
        w_sel_strong = ctr_is_strong(ctr_t'(w_sel), CTR_W);
    end

    // Registered prediction; taken/strong are held low when no lookup was made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pred_valid  <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_strong <= 1'b0;
        end else begin
            r_pred_valid  <= lu_valid;
            r_pred_taken  <= lu_valid & w_sel[CTR_W-1];
            r_pred_strong <= lu_valid & w_sel_strong;
        end
    end

    assign pred_valid  = r_pred_valid;
    assign pred_taken  = r_pred_taken;
    assign pred_strong = r_pred_strong;
    assign busy        = w_sweep;

endmodule

// File: tb/tb_bht_sat_predictor.sv
// Self-checking bench: a default-parameter predictor and a BYPASS=0 twin share
// stimulus; a CTR_W=3 / INDEX_W=4 instance is driven separately.
module tb_bht_sat_predictor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       lu_valid, fb_valid, fb_taken, clear;
    logic [7:0] lu_index, fb_index;
    logic       pv_a, pt_a, ps_a, busy_a;
    logic       pv_b, pt_b, ps_b, busy_b;

    logic       w3_lu_valid, w3_fb_valid, w3_fb_taken, w3_clear;
    logic [3:0] w3_lu_index, w3_fb_index;
    logic       pv_c, pt_c, ps_c, busy_c;

    bht_sat_predictor #(.INDEX_W(8), .CTR_W(2), .BYPASS(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .lu_valid(lu_valid), .lu_index(lu_index),
        .pred_valid(pv_a), .pred_taken(pt_a), .pred_strong(ps_a),
        .fb_valid(fb_valid), .fb_index(fb_index), .fb_taken(fb_taken),
        .clear(clear), .busy(busy_a)
    );

    bht_sat_predictor #(.INDEX_W(8), .CTR_W(2), .BYPASS(1'b0)) dut_nb (
        .clk(clk), .rst_n(rst_n),
        .lu_valid(lu_valid), .lu_index(lu_index),
        .pred_valid(pv_b), .pred_taken(pt_b), .pred_strong(ps_b),
        .fb_valid(fb_valid), .fb_index(fb_index), .fb_taken(fb_taken),
        .clear(clear), .busy(busy_b)
    );

    bht_sat_predictor #(.INDEX_W(4), .CTR_W(3)) dut_w3 (
        .clk(clk), .rst_n(rst_n),
        .lu_valid(w3_lu_valid), .lu_index(w3_lu_index),
        .pred_valid(pv_c), .pred_taken(pt_c), .pred_strong(ps_c),
        .fb_valid(w3_fb_valid), .fb_index(w3_fb_index), .fb_taken(w3_fb_taken),
        .clear(w3_clear), .busy(busy_c)
    );

    typedef struct {
        bit       luv;
        bit [7:0] lui;
        bit       fbv;
        bit [7:0] fbi;
        bit       fbt;
        bit       pv, pt, ps, pt_nb, ps_nb;
    } vec_t;

    typedef struct {
        string nm;
        bit    w3;
        bit    pv, pt, ps, pt_nb, ps_nb;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(int luv, int lui, int fbv, int fbi, int fbt,
                                int pv, int pt, int ps, int ptn, int psn);
        vec_t v;
        v.luv = (luv != 0); v.lui = 8'(lui);
        v.fbv = (fbv != 0); v.fbi = 8'(fbi); v.fbt = (fbt != 0);
        v.pv = (pv != 0); v.pt = (pt != 0); v.ps = (ps != 0);
        v.pt_nb = (ptn != 0); v.ps_nb = (psn != 0);
        return v;
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit luv, input bit [7:0] lui, input bit fbv,
                         input bit [7:0] fbi, input bit fbt, input bit clr);
        lu_valid = luv; lu_index = lui;
        fb_valid = fbv; fb_index = fbi; fb_taken = fbt;
        clear = clr;
    endtask

    task automatic drive_w3(input bit luv, input bit [3:0] lui, input bit fbv,
                            input bit [3:0] fbi, input bit fbt);
        w3_lu_valid = luv; w3_lu_index = lui;
        w3_fb_valid = fbv; w3_fb_index = fbi; w3_fb_taken = fbt;
    endtask

    task automatic idle;
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b0);
        drive_w3(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic push(input string nm, input bit w3, input bit pv, input bit pt,
                        input bit ps, input bit ptn, input bit psn);
        exp_t e;
        e.nm = nm; e.w3 = w3; e.pv = pv; e.pt = pt; e.ps = ps;
        e.pt_nb = ptn; e.ps_nb = psn;
        sb.push_back(e);
    endtask

    task automatic tick;
        @(posedge clk);
        @(negedge clk);
    endtask

    // Compare the oldest expectation against what the DUT shows now.
    task automatic check_pop;
        exp_t e;
        if (sb.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL scoreboard_empty: got 0 entries expected at least 1");
        end else begin
            e = sb.pop_front();
            if (e.w3) begin
                cmp({e.nm, ".w3.pv"}, pv_c, e.pv);
                cmp({e.nm, ".w3.pt"}, pt_c, e.pt);
                cmp({e.nm, ".w3.ps"}, ps_c, e.ps);
            end else begin
                cmp({e.nm, ".pv"}, pv_a, e.pv);
                cmp({e.nm, ".pt"}, pt_a, e.pt);
                cmp({e.nm, ".ps"}, ps_a, e.ps);
                cmp({e.nm, ".nb.pv"}, pv_b, e.pv);
                cmp({e.nm, ".nb.pt"}, pt_b, e.pt_nb);
                cmp({e.nm, ".nb.ps"}, ps_b, e.ps_nb);
            end
        end
    endtask

    // Main lookup: drive one cycle, expect the given outputs afterwards.
    task automatic look(input string nm, input bit [7:0] idx, input bit pt, input bit ps);
        drive(1'b1, idx, 1'b0, 8'd0, 1'b0, 1'b0);
        push(nm, 1'b0, 1'b1, pt, ps, pt, ps);
        tick;
        check_pop;
    endtask

    task automatic look_w3(input string nm, input bit [3:0] idx, input bit pt, input bit ps);
        drive_w3(1'b1, idx, 1'b0, 4'd0, 1'b0);
        push(nm, 1'b1, 1'b1, pt, ps, 1'b0, 1'b0);
        tick;
        check_pop;
        drive_w3(1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;

        // Counter walk on index 5 (init 1), bypass on 9, independent 10/11, bypass to strong on 12.
        vecs.push_back(mk(1,  5, 0,  0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1,  5, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1,  5, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1,  5, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  5, 0,  0, 0,  1, 1, 1, 1, 1));
        vecs.push_back(mk(0,  0, 1,  5, 1,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  5, 0,  0, 0,  1, 1, 1, 1, 1));
        vecs.push_back(mk(0,  0, 1,  5, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1,  5, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  5, 0,  0, 0,  1, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1,  5, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(0,  0, 1,  5, 0,  0, 0, 0, 0, 0));
        vecs.push_back(mk(1,  5, 0,  0, 0,  1, 0, 1, 0, 1));
        vecs.push_back(mk(1,  9, 1,  9, 1,  1, 1, 0, 0, 0));
        vecs.push_back(mk(1,  9, 0,  0, 0,  1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 10, 1, 11, 1,  1, 0, 0, 0, 0));
        vecs.push_back(mk(1, 11, 0,  0, 0,  1, 1, 0, 1, 0));
        vecs.push_back(mk(1, 12, 1, 12, 0,  1, 0, 1, 0, 0));

        rst_n = 1'b0;
        w3_clear = 1'b0;
        idle;
        repeat (3) @(negedge clk);
        cmp("rst.pv", pv_a, 0);
        cmp("rst.pt", pt_a, 0);
        cmp("rst.ps", ps_a, 0);
        cmp("rst.busy", busy_a, 0);
        cmp("rst.w3.pv", pv_c, 0);
        cmp("rst.w3.busy", busy_c, 0);
        rst_n = 1'b1;
        tick;

        foreach (vecs[i]) begin
            drive(vecs[i].luv, vecs[i].lui, vecs[i].fbv, vecs[i].fbi, vecs[i].fbt, 1'b0);
            push($sformatf("vec%0d", i), 1'b0, vecs[i].pv, vecs[i].pt, vecs[i].ps,
                 vecs[i].pt_nb, vecs[i].ps_nb);
            tick;
            check_pop;
        end

        // Train entries 0 and 255 to 3, then sweep.
        drive(1'b0, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0);   tick; tick;
        drive(1'b0, 8'd0, 1'b1, 8'd255, 1'b1, 1'b0); tick; tick;
        look("pre_clr.e0", 8'd0, 1'b1, 1'b1);
        look("pre_clr.e255", 8'd255, 1'b1, 1'b1);
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
        tick;
        idle;
        cnt = 0;
        while (busy_a && cnt < 1000) begin
            idle;
            if (cnt == 10) drive(1'b0, 8'd0, 1'b1, 8'd3, 1'b1, 1'b0);
            if (cnt == 20) begin
                drive(1'b1, 8'd255, 1'b0, 8'd0, 1'b0, 1'b0);
                push("sweep_forced", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            end
            if (cnt == 30) drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
            tick;
            if (cnt == 20) check_pop;
            cnt++;
        end
        idle;
        cmp("sweep.busy_cycles", cnt, 256);
        cmp("sweep.busy_nb", busy_b, 0);
        look("post_clr.e0", 8'd0, 1'b0, 1'b0);
        look("post_clr.e255", 8'd255, 1'b0, 1'b0);
        look("post_clr.fb_dropped", 8'd3, 1'b0, 1'b0);
        drive(1'b1, 8'd0, 1'b1, 8'd0, 1'b1, 1'b0);
        push("post_clr.bypass", 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        tick;
        check_pop;

        // Reset mid-sweep at pointer 100.
        drive(1'b0, 8'd0, 1'b1, 8'd200, 1'b1, 1'b0); tick; tick;
        look("pre_rst.e200", 8'd200, 1'b1, 1'b1);
        drive(1'b0, 8'd0, 1'b0, 8'd0, 1'b0, 1'b1);
        tick;
        idle;
        repeat (99) tick;
        drive(1'b1, 8'd7, 1'b0, 8'd0, 1'b0, 1'b0);
        tick;
        idle;
        cmp("mid_sweep.busy", busy_a, 1);
        cmp("mid_sweep.pv", pv_a, 1);
        rst_n = 1'b0;
        #1;
        cmp("async_rst.busy", busy_a, 0);
        cmp("async_rst.pv", pv_a, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick;
        cmp("after_rst.busy", busy_a, 0);
        look("after_rst.e200", 8'd200, 1'b0, 1'b0);
        look("after_rst.e150", 8'd150, 1'b0, 1'b0);
        look("after_rst.e5", 8'd5, 1'b0, 1'b0);

        // CTR_W=3 instance: init 3, saturate at 7, neighbour untouched.
        look_w3("w3.init15", 4'd15, 1'b0, 1'b0);
        drive_w3(1'b0, 4'd0, 1'b1, 4'd15, 1'b1);
        tick;
        look_w3("w3.ctr4", 4'd15, 1'b1, 1'b0);
        drive_w3(1'b0, 4'd0, 1'b1, 4'd15, 1'b1);
        repeat (7) tick;
        look_w3("w3.sat7", 4'd15, 1'b1, 1'b1);
        look_w3("w3.e14", 4'd14, 1'b0, 1'b0);
        drive_w3(1'b0, 4'd0, 1'b1, 4'd15, 1'b0);
        tick;
        look_w3("w3.ctr6", 4'd15, 1'b1, 1'b0);

        idle;
        tick;
        cmp("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/bht_sat_predictor.md
Name: bht_sat_predictor

Overview:
- Parametrised branch history table of N-bit saturating counters, one per indexed entry.
- Supplies a registered taken/not-taken prediction to the fetch stage.
- Trains counters from resolved-branch feedback issued by the execute stage.
- Generalises the fixed 4-entry, 2-bit counter: configurable depth, counter width, initial state, same-index bypass and a synchronous table clear.

Parameters:
- INDEX_W, 8, index width; table depth ENTRIES = 2**INDEX_W.
- CTR_W, 2, counter width in bits; legal range 1..4.
- CTR_INIT, 2**(CTR_W-1)-1, counter value after reset or clear (weakly not-taken).
- BYPASS, 1, 1 = a lookup hitting the same-cycle update index sees the updated value; 0 = it sees the old value.

Ports:
- clk, input, 1, single clock; all state changes on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- lu_valid, input, 1, lookup request from fetch.
- lu_index, input, INDEX_W, entry to predict.
- pred_valid, output, 1, prediction valid; registered lu_valid.
- pred_taken, output, 1, MSB of the selected counter.
- pred_strong, output, 1, selected counter is saturated (all ones or all zeros).
- fb_valid, input, 1, resolved-branch feedback valid from execute.
- fb_index, input, INDEX_W, entry to train.
- fb_taken, input, 1, actual branch outcome.
- clear, input, 1, synchronous clear of the whole table.
- busy, output, 1, high while a clear sweep is in progress.

Behaviour:
- Reset (rst_n low, asynchronous): every counter = CTR_INIT; pred_valid = 0, pred_taken = 0, pred_strong = 0, busy = 0; clear FSM returns to IDLE. Reset during a clear sweep aborts the sweep; the table is fully initialised by the reset itself.
- Lookup latency is 1 cycle. lu_valid/lu_index sampled at edge k; pred_valid/pred_taken/pred_strong valid after edge k. pred_valid = 0 in any cycle with no lookup; pred_taken and pred_strong are then 0.
- Training on edge with fb_valid = 1:
  - fb_taken = 1: counter increments, saturating at 2**CTR_W-1.
  - fb_taken = 0: counter decrements, saturating at 0.
  - No wrap-around in either direction.
- Only one entry is written per cycle. All other entries hold their value.
- Same-cycle lookup and training on the same index:
  - BYPASS = 1: prediction uses the post-update value.
  - BYPASS = 0: prediction uses the pre-update value.
  - Different indices: independent, no interaction.
- Clear FSM, states IDLE and SWEEP:
  - IDLE -> SWEEP when clear = 1. Pointer = 0, busy = 1.
  - SWEEP writes CTR_INIT to entry[pointer] each cycle and increments the pointer.
  - On the cycle the pointer reaches ENTRIES-1, it writes that entry and returns to IDLE; busy falls after that edge. A sweep takes ENTRIES cycles.
  - clear asserted while in SWEEP is ignored (no restart).
  - During SWEEP, fb_valid is ignored: the update is dropped and not queued.
  - During SWEEP, lookups still respond. pred_valid follows lu_valid; pred_taken and pred_strong are forced to the CTR_INIT-derived values.
- Arithmetic is unsigned CTR_W bits. Saturation is detected before the add, never by overflow.
- With CTR_W = 1, pred_strong is always 1.

Decomposition:
- Shared package bp_pkg holds:
  - counter update function sat_next(ctr, taken, width);
  - a strong-state helper;
  - default constant for CTR_INIT.
- One sub-module, sat_ctr_next: combinational saturating increment/decrement with the CTR_W parameter. It is reused by the update path and the bypass path.
- Table storage and the clear FSM stay in the top module.

Test Plan:
- Reset, then lookup index 5 with CTR_W = 2 -> pred_valid = 1 one cycle later, pred_taken = 0, pred_strong = 0 (counter = 1).
- Three taken feedbacks on index 5, then lookup -> pred_taken = 1, pred_strong = 1. A fourth taken feedback leaves the counter at 3 (saturation). Two not-taken feedbacks -> pred_taken = 0 (counter = 1).
- Same-cycle fb_valid (index 9, taken) and lookup index 9 from counter 1:
  - BYPASS = 1 -> pred_taken = 1;
  - BYPASS = 0 -> pred_taken = 0; the next lookup gives 1.
- Train entries 0 and 255 to 3, pulse clear -> busy high for exactly 256 cycles. A fb_valid during the sweep is dropped. Afterwards, lookups of 0 and 255 return counter 1.
- Assert rst_n low mid-sweep at pointer 100 -> busy = 0 immediately; all entries read CTR_INIT afterwards.
- CTR_W = 3, INDEX_W = 4: eight taken feedbacks on index 15 -> counter saturates at 7, pred_strong = 1. Index 14 stays unchanged at 3.
